uart_rx: RTL and testbench

- Serial receiver for the RS232 UART path: deserialises 8N1 frames (optionally 8-parity-1) from the line into bytes.
- Pairs with the existing UART transmitter: same frame format (start 0, LSB-first data, stop 1), same clk_sys domain.
- Bit timing comes from an external oversample strobe (smp_pulse, OVERSAMPLE per bit) from the shared baud generator.
- Sits between the pad synchroniser side of rxd and the RS232 channel controller byte interface.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_if.sv | 35 +++
 rtl/uart_rx_sync.sv | 43 ++++
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encodings, line-level constants, 3-way vote helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Ports: none. Imported by uart_rx, uart_rx_sync and the UART transmitter.
package uart_pkg;

  // Receiver FSM encodings. PARITY only has a path into it when parity is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_rx_state_e;

  // Line levels. These are shared with the transmitter so both ends agree on frame polarity.
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // 2-of-3 majority.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side and line-side signal bundle of the UART receiver.
// Latency: n/a (wiring only). Backpressure: none. Bytes are strobed out and not handshaken.
// Signals: rxd, smp_pulse (towards the receiver); rx_data, rx_vld, frame_err, rx_busy
// (and parity_err when UART_RX_PARITY_EN is defined) from the receiver.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rxd;
  logic                 smp_pulse;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_vld;
  logic                 frame_err;
  logic                 rx_busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;

  modport slave (
    input  rxd, smp_pulse,
    output rx_data, rx_vld, frame_err, rx_busy, parity_err
  );
  modport master (
    output rxd, smp_pulse,
    input  rx_data, rx_vld, frame_err, rx_busy, parity_err
  );
`else
  modport slave (
    input  rxd, smp_pulse,
    output rx_data, rx_vld, frame_err, rx_busy
  );
  modport master (
    output rxd, smp_pulse,
    input  rx_data, rx_vld, frame_err, rx_busy
  );
`endif
endinterface

// File: rtl/uart_rx_sync.sv
// Purpose: 2-flop synchroniser for rxd, plus a 3-sample majority vote around mid-bit.
// Latency: rxd_s_o trails rxd_i by 2 clk_sys. vote_o is valid on the smp_pulse at OVERSAMPLE/2+1.
// Backpressure: none. Ports: rxd_i/smp_pulse_i/smp_cnt_i in; rxd_s_o (synchronised line), vote_o out.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int CW         = $clog2(OVERSAMPLE)
) (
  input  logic          clk_sys,
  input  logic          rst_sys,
  input  logic          rxd_i,
  input  logic          smp_pulse_i,
  input  logic [CW-1:0] smp_cnt_i,
  output logic          rxd_s_o,
  output logic          vote_o
);

  localparam logic [CW-1:0] CNT_LO  = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE/2);

  logic meta_q, sync_q;
  logic samp_lo_q, samp_mid_q;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      meta_q     <= LINE_IDLE;
      sync_q     <= LINE_IDLE;
      samp_lo_q  <= LINE_IDLE;
      samp_mid_q <= LINE_IDLE;
    end else begin
      meta_q <= rxd_i;
      sync_q <= meta_q;
      if (smp_pulse_i && (smp_cnt_i == CNT_LO))  samp_lo_q  <= sync_q;
      if (smp_pulse_i && (smp_cnt_i == CNT_MID)) samp_mid_q <= sync_q;
    end
  end

  assign rxd_s_o = sync_q;
  // The third sample is the live line on the decision pulse itself, so no flop is needed for it.
  assign vote_o  = maj3(samp_lo_q, samp_mid_q, sync_q);

endmodule

// File: rtl/uart_rx.sv
// Purpose: UART receiver. Turns 8N1 frames on rxd into bytes (8-parity-1 with UART_RX_PARITY_EN).
// Latency: rx_vld/frame_err are strobed 1 clk_sys after the smp_pulse at stop-bit mid-decision.
// Backpressure: none. rx_data is held until the next good frame, and the consumer must take each rx_vld.
// Ports: clk_sys, rst_sys (sync, active-high); rx_if (slave): rxd, smp_pulse in;
// rx_data, rx_vld, frame_err, rx_busy out, and parity_err out when UART_RX_PARITY_EN is defined.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_ODD = 1
) (
  input  logic     clk_sys,
  input  logic     rst_sys,
  uart_rx_if.slave rx_if
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_DEC  = CW'(OVERSAMPLE/2 + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  // Out-of-range parameters are rejected at elaboration.
  if ((OVERSAMPLE < 8) || (OVERSAMPLE > 16) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
    $error("uart_rx: OVERSAMPLE must be even and in 8..16");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 8)) begin : g_bad_db
    $error("uart_rx: DATA_BITS must be in 5..8");
  end
  if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_par
    $error("uart_rx: PARITY_ODD must be 0 or 1");
  end

  uart_rx_state_e       state_q;
  logic [CW-1:0]        smp_cnt_q, smp_cnt_d;
  logic [BW-1:0]        bit_cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 rxd_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_vld_q, frame_err_q, rx_busy_q;

  logic rxd_s, vote;
  logic mid_dec, at_bnd, par_bad;

  uart_rx_sync #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_sync (
    .clk_sys     (clk_sys),
    .rst_sys     (rst_sys),
    .rxd_i       (rx_if.rxd),
    .smp_pulse_i (rx_if.smp_pulse),
    .smp_cnt_i   (smp_cnt_q),
    .rxd_s_o     (rxd_s),
    .vote_o      (vote)
  );

  always_comb begin
    smp_cnt_d = (smp_cnt_q == CNT_LAST) ? '0 : smp_cnt_q + 1'b1;
    mid_dec   = (smp_cnt_q == CNT_DEC);
    at_bnd    = (smp_cnt_q == CNT_LAST);
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);
  logic par_bit_q, parity_err_q;
  // The received parity bit differs from XOR(data) ^ sense.
  assign par_bad = par_bit_q ^ (^shreg_q) ^ PAR_SENSE;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state_q     <= ST_IDLE;
      smp_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      // rxd_q resets low, so the line has to be seen high on a sample before a fall can start
      // a frame. This way a line that is low through reset cannot fake a start edge.
      rxd_q       <= 1'b0;
      rx_data_q   <= '0;
      rx_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
      rx_busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_vld_q    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (rx_if.smp_pulse) begin
        rxd_q <= rxd_s;
        unique case (state_q)
          ST_IDLE: begin
            // Only a high-to-low transition starts a frame, so a held break stays idle.
            if ((rxd_q == LINE_IDLE) && (rxd_s == START_BIT)) begin
              state_q   <= ST_START;
              smp_cnt_q <= CNT_ONE;
              rx_busy_q <= 1'b1;
            end
          end
          ST_START: begin
            smp_cnt_q <= smp_cnt_d;
            if (mid_dec && (vote != START_BIT)) begin
              state_q   <= ST_IDLE;
              smp_cnt_q <= '0;
              rx_busy_q <= 1'b0;
            end else if (at_bnd) begin
              state_q   <= ST_DATA;
              bit_cnt_q <= '0;
            end
          end
          ST_DATA: begin
            smp_cnt_q <= smp_cnt_d;
            if (mid_dec) shreg_q <= {vote, shreg_q[DATA_BITS-1:1]};
            if (at_bnd) begin
              if (bit_cnt_q == BIT_LAST) begin
                bit_cnt_q <= '0;
`ifdef UART_RX_PARITY_EN
                state_q   <= ST_PARITY;
`else
                state_q   <= ST_STOP;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            smp_cnt_q <= smp_cnt_d;
            if (mid_dec) par_bit_q <= vote;
            if (at_bnd)  state_q   <= ST_STOP;
          end
`endif
          ST_STOP: begin
            smp_cnt_q <= smp_cnt_d;
            // Leave at mid-stop rather than at the boundary. That leaves half a bit to catch
            // the next start edge when frames are back to back.
            if (mid_dec) begin
              state_q   <= ST_IDLE;
              smp_cnt_q <= '0;
              rx_busy_q <= 1'b0;
              if (vote == STOP_BIT) begin
                if (!par_bad) begin
                  rx_data_q <= shreg_q;
                  rx_vld_q  <= 1'b1;
                end
              end else begin
                frame_err_q <= 1'b1;
              end
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_bad;
`endif
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            smp_cnt_q <= '0;
            rx_busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_vld    = rx_vld_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.rx_busy   = rx_busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of directed frames plus hand-written corner sequences.
// smp_pulse fires every 4 clk_sys (OVERSAMPLE=16, so one bit time is 64 clocks).
// Covers parity cases too when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int OS      = 16;
  localparam int DB      = 8;
  localparam int PCLK    = 4;
  localparam int BIT_CLK = OS * PCLK;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_MIN = 615 + BIT_CLK;
`else
  localparam int LAT_MIN = 615;
`endif
  localparam int LAT_MAX = LAT_MIN + 3;

  logic        clk;
  logic        rst;
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;

  uart_rx_if #(.DATA_BITS(DB)) u_if ();

  uart_rx #(
    .OVERSAMPLE (OS),
    .DATA_BITS  (DB),
    .PARITY_ODD (1)
  ) dut (
    .clk_sys (clk),
    .rst_sys (rst),
    .rx_if   (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // The pulse is seen at posedges where cyc becomes a multiple of 4.
  initial begin
    u_if.smp_pulse = 1'b0;
    forever begin
      @(negedge clk);
      u_if.smp_pulse = ((cyc % PCLK) == PCLK - 1);
    end
  end

  // Output monitor: strobe counts, captured bytes, and protocol violations.
  int          vld_total = 0, fe_total = 0, both_total = 0, long_total = 0;
  int unsigned last_vld_cyc = 0;
  logic [DB-1:0] got [0:63];
  logic        vld_prev = 1'b0, fe_prev = 1'b0;
`ifdef UART_RX_PARITY_EN
  int          pe_total = 0;
  logic        par_flip = 1'b0;
`endif

  always @(negedge clk) begin
    if (u_if.rx_vld === 1'b1) begin
      got[vld_total % 64] <= u_if.rx_data;
      vld_total           <= vld_total + 1;
      last_vld_cyc        <= cyc;
    end
    if (u_if.frame_err === 1'b1) fe_total <= fe_total + 1;
    if ((u_if.rx_vld === 1'b1) && (u_if.frame_err === 1'b1)) both_total <= both_total + 1;
    if (((u_if.rx_vld === 1'b1) && vld_prev) || ((u_if.frame_err === 1'b1) && fe_prev))
      long_total <= long_total + 1;
    vld_prev <= (u_if.rx_vld === 1'b1);
    fe_prev  <= (u_if.frame_err === 1'b1);
`ifdef UART_RX_PARITY_EN
    if (u_if.parity_err === 1'b1) pe_total <= pe_total + 1;
`endif
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int nclk);
    u_if.rxd = 1'b1;
    repeat (nclk) @(negedge clk);
  endtask

  // One bit time. The glitch inverts the line for one smp_pulse period near mid-bit.
  task automatic send_bit(input logic b, input logic glitch);
    u_if.rxd = b;
    if (glitch) begin
      repeat (30) @(negedge clk);
      u_if.rxd = ~b;
      repeat (PCLK) @(negedge clk);
      u_if.rxd = b;
      repeat (BIT_CLK - 30 - PCLK) @(negedge clk);
    end else begin
      repeat (BIT_CLK) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic glitch);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i], glitch && (i == 2));
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ 1'b1 ^ par_flip, 1'b0);
`endif
    send_bit(stop, 1'b0);
  endtask

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       stop;
    logic       glitch;
    int         exp_vld;
    int         exp_fe;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          v0, f0, lat;
    int unsigned t0;
`ifdef UART_RX_PARITY_EN
    int          p0;
`endif

    vecs[0] = '{"glitch_3c", 8'h3C, 1'b1, 1'b1, 1, 0, 8'h3C};
    vecs[1] = '{"byte_01",   8'h01, 1'b1, 1'b0, 1, 0, 8'h01};
    vecs[2] = '{"byte_80",   8'h80, 1'b1, 1'b0, 1, 0, 8'h80};
    vecs[3] = '{"byte_5a",   8'h5A, 1'b1, 1'b0, 1, 0, 8'h5A};
    vecs[4] = '{"ferr_c3",   8'hC3, 1'b0, 1'b0, 0, 1, 8'h5A};
    vecs[5] = '{"byte_7e",   8'h7E, 1'b1, 1'b0, 1, 0, 8'h7E};

    // Reset state
    rst      = 1'b1;
    u_if.rxd = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_rx_data", u_if.rx_data, 8'h00);
    check("rst_rx_vld", u_if.rx_vld, 1'b0);
    check("rst_frame_err", u_if.frame_err, 1'b0);
    check("rst_rx_busy", u_if.rx_busy, 1'b0);
`ifdef UART_RX_PARITY_EN
    check("rst_parity_err", u_if.parity_err, 1'b0);
`endif
    rst = 1'b0;
    idle(2 * BIT_CLK);

    // Basic byte with latency from the start edge
    v0 = vld_total; f0 = fe_total; t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(2 * BIT_CLK);
    check("basic_vld_cnt", vld_total - v0, 1);
    check("basic_data", u_if.rx_data, 8'hA5);
    check("basic_fe_cnt", fe_total - f0, 0);
    check("basic_busy_after", u_if.rx_busy, 1'b0);
    lat = int'(last_vld_cyc - t0);
    checks++;
    if ((lat < LAT_MIN) || (lat > LAT_MAX)) begin
      failures++;
      $display("FAIL basic_latency: got %0d cycles, expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
    end

    // Back-to-back frames, no idle gap
    v0 = vld_total; f0 = fe_total;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(2 * BIT_CLK);
    check("b2b_vld_cnt", vld_total - v0, 2);
    check("b2b_first", got[v0 % 64], 8'h00);
    check("b2b_second", got[(v0 + 1) % 64], 8'hFF);
    check("b2b_fe_cnt", fe_total - f0, 0);

    // False start: 3-pulse low glitch on an idle line
    v0 = vld_total; f0 = fe_total;
    u_if.rxd = 1'b0;
    repeat (10) @(negedge clk);
    check("fs_busy_mid", u_if.rx_busy, 1'b1);
    repeat (3 * PCLK - 10) @(negedge clk);
    idle(2 * BIT_CLK);
    check("fs_busy_after", u_if.rx_busy, 1'b0);
    check("fs_vld_cnt", vld_total - v0, 0);
    check("fs_fe_cnt", fe_total - f0, 0);

    // Table of directed frames
    for (int i = 0; i < 6; i++) begin
      v0 = vld_total; f0 = fe_total;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].glitch);
      idle(2 * BIT_CLK);
      check({vecs[i].name, "_vld_cnt"}, vld_total - v0, vecs[i].exp_vld);
      check({vecs[i].name, "_fe_cnt"}, fe_total - f0, vecs[i].exp_fe);
      check({vecs[i].name, "_data"}, u_if.rx_data, vecs[i].exp_data);
      check({vecs[i].name, "_busy"}, u_if.rx_busy, 1'b0);
    end

    // Framing error followed by a 20-bit break; no re-trigger while low
    v0 = vld_total; f0 = fe_total;
    send_frame(8'h55, 1'b0, 1'b0);
    u_if.rxd = 1'b0;
    repeat (20 * BIT_CLK) @(negedge clk);
    check("brk_fe_cnt", fe_total - f0, 1);
    check("brk_vld_cnt", vld_total - v0, 0);
    check("brk_data_held", u_if.rx_data, 8'h7E);
    check("brk_busy", u_if.rx_busy, 1'b0);
    idle(2 * BIT_CLK);
    send_frame(8'h96, 1'b1, 1'b0);
    idle(2 * BIT_CLK);
    check("brk_recover_data", u_if.rx_data, 8'h96);
    check("brk_recover_vld", vld_total - v0, 1);

    // Reset in the middle of bit 4 of 0x81
    v0 = vld_total; f0 = fe_total;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    for (int i = 1; i < 4; i++) send_bit(1'b0, 1'b0);
    u_if.rxd = 1'b0;
    repeat (BIT_CLK / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_rx_data", u_if.rx_data, 8'h00);
    check("mrst_rx_vld", u_if.rx_vld, 1'b0);
    check("mrst_frame_err", u_if.frame_err, 1'b0);
    check("mrst_rx_busy", u_if.rx_busy, 1'b0);
    // Release just after a sample pulse, so the synchroniser has flushed before the next sample.
    repeat (4) @(negedge clk);
    while ((cyc % PCLK) != 0) @(negedge clk);
    rst = 1'b0;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("mrst_no_trigger", u_if.rx_busy, 1'b0);
    idle(2 * BIT_CLK);
    send_frame(8'h42, 1'b1, 1'b0);
    idle(2 * BIT_CLK);
    check("mrst_next_data", u_if.rx_data, 8'h42);
    check("mrst_vld_cnt", vld_total - v0, 1);
    check("mrst_fe_cnt", fe_total - f0, 0);

`ifdef UART_RX_PARITY_EN
    // Odd parity: 0x07 carries parity bit 0
    v0 = vld_total; p0 = pe_total;
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2 * BIT_CLK);
    check("par_ok_vld", vld_total - v0, 1);
    check("par_ok_data", u_if.rx_data, 8'h07);
    check("par_ok_pe", pe_total - p0, 0);
    v0 = vld_total; p0 = pe_total;
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2 * BIT_CLK);
    send_frame(8'h18, 1'b1, 1'b0);
    idle(2 * BIT_CLK);
    par_flip = 1'b0;
    check("par_bad_vld", vld_total - v0, 0);
    check("par_bad_pe", pe_total - p0, 2);
    check("par_bad_data_held", u_if.rx_data, 8'h07);
`endif

    check("never_vld_and_fe", both_total, 0);
    check("strobes_one_cycle", long_total, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
